tp_main: RTL and testbench
==========================

// Module: tp_main
// PURPOSE
//  Toy top level of the TP main FPGA datapath. Accepts a 65-bit word stream: bit 64 is the
//  metadata flag, bits 63:0 are payload. Events are framed by metadata header/footer words.
//  The block forwards framed events with fixed latency and tags each header with an event
//  sequence number. It fills each footer with the data-word count and drops unframed words.
// PARAMETERS
//  W        65  word width incl. metadata flag at bit W-1 (only 65 is supported)
//  SEQ_W    16  event sequence number width, written into header bits [47:32]
//  CNT_W    16  data-word count width, written into footer bits [15:0]
// PORTS
//  clk         in   1   single clock, all logic rising-edge
//  rst         in   1   asynchronous, active-high reset
//  din         in   65  input word; din[64]=metadata flag, din[63:0]=payload
//  din_valid   in   1   din is valid this cycle (no backpressure; every valid word is consumed)
//  dout        out  65  output word, same format as din
//  dout_valid  out  1   dout is valid this cycle
// BEHAVIOUR
//  - Word classes (when din_valid=1):
//    HEADER = din[64]=1 and din[63]=1;  FOOTER = din[64]=1 and din[63]=0;  DATA = din[64]=0.
//  - Pipeline: stage 1 registers din/din_valid; stage 2 classifies, edits and registers the output.
//    A word at the input on edge N appears at dout/dout_valid after edge N+2 (latency 2 clocks).
//  - FSM, 2 states, updated by stage-2 words only:
//    IDLE: HEADER -> emit, go to IN_EVT; DATA -> drop; FOOTER -> drop.
//    IN_EVT: DATA -> emit unchanged, cnt++ (saturate at 0xFFFF); FOOTER -> emit, go to IDLE;
//            HEADER -> emit as a new event start and stay in IN_EVT. The unterminated
//            event gets no footer.
//  - Header edit: dout[47:32] = seq (the current value); other bits pass through. seq increments
//    by 1 after every emitted header and wraps 0xFFFF->0x0000.
//  - Footer edit: dout[15:0] = cnt, the number of DATA words emitted since the header (saturated).
//    Other bits pass through. cnt clears to 0 on every emitted header.
//  - Dropped words: dout_valid=0 that cycle, and dout holds its previous value.
//  - Idle cycles (din_valid=0) are not words. They do not change the FSM, seq, cnt or dout.
//    dout_valid=0 on those cycles.
//  - Gaps in din_valid inside an event are allowed. The output shows the same gaps, delayed.
//  - Reset (async assert, any time incl. mid-event): dout=0, dout_valid=0, both pipeline stages
//    invalid, FSM=IDLE, seq=0, cnt=0. After deassertion the block is in IDLE. A partial event
//    in flight is lost, and any following DATA/FOOTER words are dropped until the next HEADER.
//  - Output registers only change on clk rising edges (no combinational din->dout path).
// TESTING
//  1 Reset: hold rst=1 with din_valid=1 toggling -> dout=0, dout_valid=0 throughout.
//  2 Basic event: HEADER 0x1_8000_0000_0000_0000, DATA 0x0_0000_0000_0000_00AA,
//    DATA 0x0_..._00BB, FOOTER 0x1_0000_0000_0000_0000 on consecutive cycles
//    -> 2 clocks later: 0x1_8000_0000_0000_0000, 0x0..AA, 0x0..BB, 0x1_0000_0000_0000_0002;
//    dout_valid=1 for 4 cycles.
//  3 Second event after 1: same header -> dout=0x1_8000_0001_0000_0000 (seq=1);
//    footer after 0 data words -> [15:0]=0x0000.
//  4 Unframed words: DATA 0x0..11 and FOOTER while IDLE -> dout_valid stays 0 and dout unchanged.
//    The next HEADER is emitted normally.
//  5 Mid-event reset: HEADER, DATA, rst pulse, DATA 0x0..22, FOOTER -> after the reset nothing
//    is output. A subsequent HEADER is emitted with seq=0.
//  6 Back-to-back HEADER in IN_EVT, plus valid gaps: HEADER, DATA, (din_valid=0), HEADER, DATA,
//    FOOTER -> headers carry seq 0 and 1. The footer count is 1, and the gap is preserved at
//    the output.

Source files
------------

// File: rtl/tp_main.sv
// TP main datapath toy top: frames metadata-delimited events, stamps headers with a
// sequence number and footers with the data-word count, and drops unframed words.
module tp_main #(
  parameter int W     = 65,
  parameter int SEQ_W = 16,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic [W-1:0] dout,
  output logic         dout_valid
);

  typedef enum logic {IDLE, IN_EVT} state_t;

  localparam int SEQ_LSB = 32;
  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0]     r_s1Word;
  logic             r_s1Valid;
  state_t           r_state;
  logic [SEQ_W-1:0] r_seq;
  logic [CNT_W-1:0] r_cnt;

  logic             w_isHeader;
  logic             w_isFooter;
  logic             w_isData;
  logic [W-1:0]     w_headerWord;
  logic [W-1:0]     w_footerWord;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Word  <= '0;
      r_s1Valid <= 1'b0;
    end else begin
      r_s1Word  <= din;
      r_s1Valid <= din_valid;
    end
  end

  always_comb begin
    w_isData     = ~r_s1Word[W-1];
    w_isHeader   = r_s1Word[W-1] & r_s1Word[W-2];
    w_isFooter   = r_s1Word[W-1] & ~r_s1Word[W-2];
    w_headerWord = r_s1Word;
    w_headerWord[SEQ_LSB +: SEQ_W] = r_seq;
    w_footerWord = r_s1Word;
    w_footerWord[CNT_W-1:0] = r_cnt;
  end

  // Idle stage-2 slots leave FSM, counters and dout untouched; only dout_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_seq      <= '0;
      r_cnt      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (r_s1Valid) begin
        if (w_isHeader) begin
          dout       <= w_headerWord;
          dout_valid <= 1'b1;
          r_seq      <= r_seq + SEQ_ONE;
          r_cnt      <= '0;
          r_state    <= IN_EVT;
        end else if (r_state == IN_EVT) begin
          if (w_isData) begin
            dout       <= r_s1Word;
            dout_valid <= 1'b1;
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else if (w_isFooter) begin
            dout       <= w_footerWord;
            dout_valid <= 1'b1;
            r_state    <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tp_main.sv
// Self-checking bench for tp_main: directed event scenarios plus a random event stream,
// with a latency-aware scoreboard matching every emitted word.
module tb_tp_main;

  logic        clk;
  logic        rst;
  logic [64:0] din;
  logic        din_valid;
  logic [64:0] dout;
  logic        dout_valid;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  typedef struct {
    logic [64:0] word;
    int          cycle;
  } exp_t;

  exp_t sbQ[$];

  logic        mInEvt;
  logic [15:0] mSeq;
  logic [15:0] mCnt;

  tp_main dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Every valid output must match the oldest expected word and arrive on its cycle.
  always @(negedge clk) begin
    if (!rst && dout_valid === 1'b1) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: dout=%h dout_valid=1 at cycle %0d, none required",
                 dout, cycleCount);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        if (dout !== e.word || cycleCount != e.cycle) begin
          errors++;
          $display("[TB] FAIL scoreboard: got %h at cycle %0d, required %h at cycle %0d",
                   dout, cycleCount, e.word, e.cycle);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [64:0] w, input logic emit, input logic [64:0] expW);
    exp_t e;
    @(posedge clk);
    #1;
    din       = w;
    din_valid = 1'b1;
    if (emit) begin
      e.word  = expW;
      e.cycle = cycleCount + 2;
      sbQ.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din       = {$urandom, $urandom, $urandom};
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #1;
    rst       = 1'b1;
    din_valid = 1'b0;
    sbQ.delete();
    mInEvt = 1'b0;
    mSeq   = '0;
    mCnt   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drainAndCheck(input string name);
    idleCycles(4);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: %0d words still pending, required 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      din_valid = i[0];
      din       = {1'b1, 1'b1, 31'h0, $urandom};
      @(negedge clk);
      checks++;
      if (dout !== 65'h0 || dout_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold: dout=%h dout_valid=%b, required 0/0", dout, dout_valid);
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_basic_event();
    applyStimulus(65'h1_8000_0000_0000_0000, 1'b1, 65'h1_8000_0000_0000_0000);
    applyStimulus(65'h0_0000_0000_0000_00AA, 1'b1, 65'h0_0000_0000_0000_00AA);
    applyStimulus(65'h0_0000_0000_0000_00BB, 1'b1, 65'h0_0000_0000_0000_00BB);
    applyStimulus(65'h1_0000_0000_0000_0000, 1'b1, 65'h1_0000_0000_0000_0002);
    drainAndCheck("basic");
  endtask

  task automatic test_second_event();
    applyStimulus(65'h1_8000_0000_0000_0000, 1'b1, 65'h1_8000_0001_0000_0000);
    applyStimulus(65'h1_0000_0000_0000_0000, 1'b1, 65'h1_0000_0000_0000_0000);
    drainAndCheck("second");
  endtask

  task automatic test_unframed();
    applyStimulus(65'h0_0000_0000_0000_0011, 1'b0, 65'h0);
    applyStimulus(65'h1_0000_0000_0000_1234, 1'b0, 65'h0);
    drainAndCheck("unframed");
    checks++;
    if (dout !== 65'h1_0000_0000_0000_0000 || dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unframed_hold: dout=%h valid=%b, required 10000000000000000/0",
               dout, dout_valid);
    end
    applyStimulus(65'h1_8000_0000_0000_0000, 1'b1, 65'h1_8000_0002_0000_0000);
    applyStimulus(65'h1_0000_0000_0000_0000, 1'b1, 65'h1_0000_0000_0000_0000);
    drainAndCheck("unframed_header");
  endtask

  task automatic test_mid_event_reset();
    applyStimulus(65'h1_8000_0000_0000_0000, 1'b1, 65'h1_8000_0003_0000_0000);
    applyStimulus(65'h0_0000_0000_0000_0055, 1'b0, 65'h0);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dout !== 65'h0 || dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: dout=%h valid=%b, required 0/0", dout, dout_valid);
    end
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_header: %0d words pending, required 0", sbQ.size());
      sbQ.delete();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(65'h0_0000_0000_0000_0022, 1'b0, 65'h0);
    applyStimulus(65'h1_0000_0000_0000_0000, 1'b0, 65'h0);
    drainAndCheck("midreset_drop");
    checks++;
    if (dout !== 65'h0) begin
      errors++;
      $display("[TB] FAIL midreset_dout: dout=%h, required 0", dout);
    end
    applyStimulus(65'h1_8000_0000_0000_0000, 1'b1, 65'h1_8000_0000_0000_0000);
    drainAndCheck("midreset_header");
  endtask

  task automatic test_back_to_back();
    applyReset();
    applyStimulus(65'h1_8000_0000_0000_0000, 1'b1, 65'h1_8000_0000_0000_0000);
    applyStimulus(65'h0_0000_0000_0000_0001, 1'b1, 65'h0_0000_0000_0000_0001);
    idleCycles(1);
    applyStimulus(65'h1_8000_0000_0000_0000, 1'b1, 65'h1_8000_0001_0000_0000);
    applyStimulus(65'h0_0000_0000_0000_0002, 1'b1, 65'h0_0000_0000_0000_0002);
    applyStimulus(65'h1_0000_0000_0000_0000, 1'b1, 65'h1_0000_0000_0000_0001);
    drainAndCheck("back_to_back");
  endtask

  task automatic test_saturation();
    applyReset();
    applyStimulus(65'h1_8000_0000_0000_0000, 1'b1, 65'h1_8000_0000_0000_0000);
    for (int i = 0; i < 65537; i++) begin
      applyStimulus({1'b0, 32'h0, i}, 1'b1, {1'b0, 32'h0, i});
    end
    applyStimulus(65'h1_0000_0000_0000_0000, 1'b1, 65'h1_0000_0000_0000_FFFF);
    drainAndCheck("saturation");
  endtask

  // Random stream checked against a behavioural model of framing, seq and count.
  task automatic test_random_stream();
    logic [64:0] w;
    logic [64:0] e;
    logic        emit;
    int          kind;
    applyReset();
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      w    = {$urandom, $urandom, $urandom};
      if (kind < 2) begin
        w[64:63] = 2'b11;
      end else if (kind < 4) begin
        w[64:63] = 2'b10;
      end else begin
        w[64] = 1'b0;
      end
      e    = w;
      emit = 1'b0;
      if (w[64] && w[63]) begin
        e[47:32] = mSeq;
        emit     = 1'b1;
        mSeq     = mSeq + 16'd1;
        mCnt     = '0;
        mInEvt   = 1'b1;
      end else if (w[64] && mInEvt) begin
        e[15:0] = mCnt;
        emit    = 1'b1;
        mInEvt  = 1'b0;
      end else if (!w[64] && mInEvt) begin
        emit = 1'b1;
        if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      end
      applyStimulus(w, emit, e);
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end
    drainAndCheck("random");
  endtask

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    mInEvt    = 1'b0;
    mSeq      = '0;
    mCnt      = '0;
    test_reset();
    test_basic_event();
    test_second_event();
    test_unframed();
    test_mid_event_reset();
    test_back_to_back();
    test_random_stream();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
